// File: rtl/multicycle_ctrl.sv
// LEGv8 multicycle control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared ready-handshaked memory, flagging illegal opcodes and memory timeouts.
//
// state   | meaning
// FETCH   | read instruction at PC, latch IR, PC <= PC+4
// DECODE  | ALUOut <= branch target, dispatch on opcode
// MEMADR  | ALUOut <= A + SignImm
// MEMRD   | data read at ALUOut, wait for mem_ready
// MEMWB   | register file <= MDR
// MEMWR   | data write at ALUOut, wait for mem_ready
// EXEC    | R-type ALU operation
// ALUWB   | register file <= ALUOut
// BRANCH  | CBZ: PC <= ALUOut when zero
// ILLEGAL | exception pulse, resume at next instruction
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] Op,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [3:0]  state,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        PCSrc,
   output logic        Reg2Loc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        exc,
   output logic [1:0]  exc_code,
   output logic        retire
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ILLEGAL = 4'd9
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         exc_code_q, exc_code_d;

   logic is_ldur, is_stur, is_cbz, is_rtype;
   logic wait_st, timeout;

   assign is_ldur  = (Op == 11'b11111000010);
   assign is_stur  = (Op == 11'b11111000000);
   assign is_cbz   = (Op[10:3] == 8'b10110100);
   assign is_rtype = (Op == 11'b10001011000) || (Op == 11'b11001011000) ||
                     (Op == 11'b10001010000) || (Op == 11'b10101010000);

   assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   // A ready in the same cycle the count hits the limit wins over the timeout.
   assign timeout = wait_st && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (is_ldur || is_stur) state_d = S_MEMADR;
            else if (is_rtype)      state_d = S_EXEC;
            else if (is_cbz)        state_d = S_BRANCH;
            else                    state_d = S_ILLEGAL;
         end
         S_MEMADR:  state_d = is_ldur ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   if (mem_ready) state_d = S_FETCH;
         S_EXEC:    state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ILLEGAL: state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
      if (timeout) state_d = S_FETCH;

      cnt_d = (wait_st && !mem_ready && !timeout) ? cnt_q + CNT_W'(1) : '0;

      exc_code_d = exc_code_q;
      if (timeout)                     exc_code_d = 2'b10;
      else if (state_q == S_ILLEGAL)   exc_code_d = 2'b01;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         cnt_q      <= '0;
         exc_code_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         exc_code_q <= exc_code_d;
      end
   end

   always_comb begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      AdrSrc   = 1'b0;
      PCSrc    = 1'b0;
      ALUSrcA  = 2'b00;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      exc      = 1'b0;
      retire   = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b11;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            retire   = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            AdrSrc   = 1'b1;
            retire   = mem_ready;
         end
         S_EXEC: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            PCSrc   = 1'b1;
            PCWrite = zero;
            retire  = 1'b1;
         end
         S_ILLEGAL: exc = 1'b1;
         default: ;
      endcase
      if (timeout) begin
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         retire   = 1'b0;
         exc      = 1'b1;
      end
      // Reset aborts the current instruction with no side effects this cycle.
      if (reset) begin
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         retire   = 1'b0;
         exc      = 1'b0;
      end
   end

   assign Reg2Loc  = is_stur || is_cbz;
   assign state    = state_q;
   assign exc_code = reset ? 2'b00 : (exc ? exc_code_d : exc_code_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors are queued
// as stimulus is driven and popped/compared at the falling edge.
module tb_multicycle_ctrl;

   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_BAD  = 11'b10101011010;

   typedef struct packed {
      logic [3:0] st;
      logic       irw, pcw, adr, pcsrc, r2l;
      logic [1:0] sa, sb, aop;
      logic       mrd, mwr, m2r, rw, exc;
      logic [1:0] ec;
      logic       ret;
   } outv_t;

   logic        clk = 1'b0;
   logic        reset, zero, mem_ready;
   logic [10:0] op;
   logic [3:0]  state;
   logic        IRWrite, PCWrite, AdrSrc, PCSrc, Reg2Loc;
   logic [1:0]  ALUSrcA, ALUSrcB, ALUOp;
   logic        MemRead, MemWrite, MemtoReg, RegWrite, exc, retire;
   logic [1:0]  exc_code;

   outv_t exp_q[$];
   string tag_q[$];
   logic [1:0] exp_ec;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .Op(op), .zero(zero), .mem_ready(mem_ready),
      .state(state), .IRWrite(IRWrite), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .PCSrc(PCSrc), .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .exc(exc), .exc_code(exc_code), .retire(retire)
   );

   // Unconditional per-state outputs from the state table; conditional ones set by the caller.
   function automatic outv_t mk(input logic [3:0] st);
      outv_t e;
      e     = '0;
      e.st  = st;
      e.r2l = (op == OP_STUR) || (op[10:3] == 8'b10110100);
      e.ec  = exp_ec;
      case (st)
         4'd0: begin e.mrd = 1'b1; e.sb = 2'b01; end
         4'd1: begin e.sa = 2'b01; e.sb = 2'b11; end
         4'd2: begin e.sa = 2'b10; e.sb = 2'b10; end
         4'd3: begin e.mrd = 1'b1; e.adr = 1'b1; end
         4'd4: begin e.rw = 1'b1; e.m2r = 1'b1; e.ret = 1'b1; end
         4'd5: begin e.mwr = 1'b1; e.adr = 1'b1; end
         4'd6: begin e.sa = 2'b10; e.aop = 2'b10; end
         4'd7: begin e.rw = 1'b1; e.ret = 1'b1; end
         4'd8: begin e.sa = 2'b10; e.aop = 2'b01; e.pcsrc = 1'b1; e.ret = 1'b1; end
         4'd9: e.exc = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   task automatic step(input string tag, input outv_t e, input logic mr, input logic z,
                       input logic rst);
      outv_t obs, exp_v;
      string t;
      reset     = rst;
      mem_ready = mr;
      zero      = z;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      obs = {state, IRWrite, PCWrite, AdrSrc, PCSrc, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp,
             MemRead, MemWrite, MemtoReg, RegWrite, exc, exc_code, retire};
      exp_v = exp_q.pop_front();
      t     = tag_q.pop_front();
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", t, obs, exp_v);
      end
      @(posedge clk);
      #1;
   endtask

   // Fetch with ready: IR and PC latch.
   task automatic fetch_ok(input string tag);
      outv_t e;
      e     = mk(4'd0);
      e.irw = 1'b1;
      e.pcw = 1'b1;
      step(tag, e, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      outv_t e;
      reset     = 1'b1;
      mem_ready = 1'b0;
      zero      = 1'b0;
      op        = OP_ADD;
      exp_ec    = 2'b00;
      @(posedge clk);
      #1;

      step("reset_hold", mk(4'd0), 1'b1, 1'b0, 1'b1);
      step("after_reset", mk(4'd0), 1'b0, 1'b0, 1'b0);

      // ADD
      fetch_ok("add_fetch");
      step("add_decode", mk(4'd1), 1'b1, 1'b0, 1'b0);
      step("add_exec", mk(4'd6), 1'b1, 1'b0, 1'b0);
      step("add_aluwb", mk(4'd7), 1'b1, 1'b0, 1'b0);

      // LDUR with 3 wait cycles in MEMRD
      op = OP_LDUR;
      fetch_ok("ldur_fetch");
      step("ldur_decode", mk(4'd1), 1'b1, 1'b0, 1'b0);
      step("ldur_memadr", mk(4'd2), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("ldur_memrd_wait", mk(4'd3), 1'b0, 1'b0, 1'b0);
      step("ldur_memrd_ready", mk(4'd3), 1'b1, 1'b0, 1'b0);
      step("ldur_memwb", mk(4'd4), 1'b1, 1'b0, 1'b0);

      // STUR with one wait cycle in MEMWR
      op = OP_STUR;
      fetch_ok("stur_fetch");
      step("stur_decode", mk(4'd1), 1'b1, 1'b0, 1'b0);
      step("stur_memadr", mk(4'd2), 1'b1, 1'b0, 1'b0);
      step("stur_memwr_wait", mk(4'd5), 1'b0, 1'b0, 1'b0);
      e = mk(4'd5); e.ret = 1'b1;
      step("stur_memwr_ready", e, 1'b1, 1'b0, 1'b0);

      // CBZ taken then not taken
      op = OP_CBZ;
      fetch_ok("cbz1_fetch");
      step("cbz1_decode", mk(4'd1), 1'b1, 1'b1, 1'b0);
      e = mk(4'd8); e.pcw = 1'b1;
      step("cbz_taken", e, 1'b1, 1'b1, 1'b0);
      fetch_ok("cbz2_fetch");
      step("cbz2_decode", mk(4'd1), 1'b1, 1'b0, 1'b0);
      step("cbz_not_taken", mk(4'd8), 1'b1, 1'b0, 1'b0);

      // Illegal opcode
      op = OP_BAD;
      fetch_ok("ill_fetch");
      step("ill_decode", mk(4'd1), 1'b1, 1'b0, 1'b0);
      exp_ec = 2'b01;
      step("ill_exc", mk(4'd9), 1'b1, 1'b0, 1'b0);

      // FETCH timeout: 15 waiting cycles, exception on the 16th
      for (int i = 0; i < 15; i++) step("fetch_wait", mk(4'd0), 1'b0, 1'b0, 1'b0);
      exp_ec = 2'b10;
      e = mk(4'd0); e.exc = 1'b1;
      step("fetch_timeout", e, 1'b0, 1'b0, 1'b0);

      // Same count, but ready arrives on the limit cycle
      op = OP_STUR;
      for (int i = 0; i < 15; i++) step("fetch_wait2", mk(4'd0), 1'b0, 1'b0, 1'b0);
      fetch_ok("fetch_ready_at_limit");
      step("rst_decode", mk(4'd1), 1'b1, 1'b0, 1'b0);
      step("rst_memadr", mk(4'd2), 1'b1, 1'b0, 1'b0);

      // Reset during MEMWR with ready: no write, no retire
      exp_ec = 2'b00;
      e = mk(4'd5); e.mwr = 1'b0;
      step("reset_in_memwr", e, 1'b1, 1'b0, 1'b1);
      step("after_abort", mk(4'd0), 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
